// File: rtl/bw_wb_queue_if.sv
// Handshake and register-file write bundle for bw_wb_queue.
// The master modport is the queue's view; slave is the view of whoever drives the sources and consumes the writes.
interface bw_wb_queue_if #(
  parameter int N_SRC  = 4,
  parameter int CNTW   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic                          stall;
  logic [N_SRC-1:0]              src_v;
  logic                          src_rdy;
  logic [N_SRC-1:0][5:0]         src_tgt;
  logic [N_SRC-1:0][DATA_W-1:0]  src_res;
  logic [N_SRC-1:0][ADDR_W-1:0]  src_ip;
  logic                          wr0, wr1, wr2;
  logic [5:0]                    wa0, wa1, wa2;
  logic [DATA_W-1:0]             i0, i1, i2;
  logic [ADDR_W-1:0]             ip0, ip1, ip2;
  logic [CNTW-1:0]               count;
  logic                          empty;

  modport master (
    input  stall, src_v, src_tgt, src_res, src_ip,
    output src_rdy, wr0, wr1, wr2, wa0, wa1, wa2, i0, i1, i2, ip0, ip1, ip2, count, empty
  );

  modport slave (
    output stall, src_v, src_tgt, src_res, src_ip,
    input  src_rdy, wr0, wr1, wr2, wa0, wa1, wa2, i0, i1, i2, ip0, ip1, ip2, count, empty
  );
endinterface

// File: rtl/bw_wb_queue.sv
// In-order writeback queue: collects up to N_SRC results per cycle and drains up to three
// per cycle onto the register file write ports, oldest on port 0.
module bw_wb_queue #(
  parameter int N_SRC  = 4,
  parameter int DEPTH  = 8,
  parameter int CNTW   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  bw_wb_queue_if.master q
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] RDY_MAX = CNTW'(DEPTH - N_SRC);

  typedef struct packed {
    logic [5:0]        tgt;
    logic [DATA_W-1:0] res;
    logic [ADDR_W-1:0] ip;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]   count_q, count_d, enq_n;
  logic [N_SRC-1:0]  take;
  logic [PW-1:0]     slot [N_SRC];
  logic [1:0]        deq_k;
  logic              rdy;
  logic [2:0]        wr_v;
  logic [5:0]        wa_v [3];
  logic [DATA_W-1:0] i_v  [3];
  logic [ADDR_W-1:0] ip_v [3];

  // Ready looks only at the registered count, so it never depends on src_v or stall.
  assign rdy = !rst && (count_q <= RDY_MAX);

  always_comb begin
    enq_n = '0;
    for (int s = 0; s < N_SRC; s++) begin
      slot[s] = tail_q + PW'(enq_n);
      take[s] = rdy && q.src_v[s] && (q.src_tgt[s] != 6'd0);
      if (take[s]) enq_n = enq_n + CNTW'(1);
    end
  end

  always_comb begin
    if (rst || q.stall)           deq_k = 2'd0;
    else if (count_q >= CNTW'(3)) deq_k = 2'd3;
    else                          deq_k = count_q[1:0];
  end

  // Ports fill from 0 upward; unused ports are forced to zero rather than showing stale entries.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      wr_v[j] = (2'(j) < deq_k);
      wa_v[j] = '0;
      i_v[j]  = '0;
      ip_v[j] = '0;
      if (wr_v[j]) begin
        wa_v[j] = mem_q[head_q + PW'(j)].tgt;
        i_v[j]  = mem_q[head_q + PW'(j)].res;
        ip_v[j] = mem_q[head_q + PW'(j)].ip;
      end
    end
  end

  assign head_d  = head_q + PW'(deq_k);
  assign tail_d  = tail_q + PW'(enq_n);
  assign count_d = count_q + enq_n - CNTW'(deq_k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < N_SRC; s++) begin
      if (take[s]) mem_q[slot[s]] <= '{tgt: q.src_tgt[s], res: q.src_res[s], ip: q.src_ip[s]};
    end
  end

  assign q.src_rdy = rdy;
  assign q.count   = count_q;
  assign q.empty   = (count_q == '0);
  assign q.wr0 = wr_v[0];
  assign q.wr1 = wr_v[1];
  assign q.wr2 = wr_v[2];
  assign q.wa0 = wa_v[0];
  assign q.wa1 = wa_v[1];
  assign q.wa2 = wa_v[2];
  assign q.i0  = i_v[0];
  assign q.i1  = i_v[1];
  assign q.i2  = i_v[2];
  assign q.ip0 = ip_v[0];
  assign q.ip1 = ip_v[1];
  assign q.ip2 = ip_v[2];
endmodule

// File: tb/tb_bw_wb_queue.sv
// Directed bench for bw_wb_queue: hand-computed expectations checked with immediate assertions.
module tb_bw_wb_queue;
  localparam int N_SRC  = 4;
  localparam int DEPTH  = 8;
  localparam int CNTW   = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [5:0]        sb_tgt [$];
  logic [DATA_W-1:0] sb_res [$];

  bw_wb_queue_if #(.N_SRC(N_SRC), .CNTW(CNTW), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bw_wb_queue #(.N_SRC(N_SRC), .DEPTH(DEPTH), .CNTW(CNTW), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [5:0] tgt, input logic [DATA_W-1:0] res);
    bus.src_v[s]   = 1'b1;
    bus.src_tgt[s] = tgt;
    bus.src_res[s] = res;
    bus.src_ip[s]  = ADDR_W'(32'h1000) + ADDR_W'(tgt);
  endtask

  task automatic clr_src();
    bus.src_v = '0;
  endtask

  // A live port must carry the entry with ip = 0x1000+tgt; an idle port must be all zero.
  task automatic chk_port(input string tag, input int j, input logic ew,
                          input logic [5:0] ewa, input logic [DATA_W-1:0] ei);
    logic              w;
    logic [5:0]        a;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] p;
    case (j)
      0:       begin w = bus.wr0; a = bus.wa0; d = bus.i0; p = bus.ip0; end
      1:       begin w = bus.wr1; a = bus.wa1; d = bus.i1; p = bus.ip1; end
      default: begin w = bus.wr2; a = bus.wa2; d = bus.i2; p = bus.ip2; end
    endcase
    chk({tag, "_wr"}, 64'(w), 64'(ew));
    chk({tag, "_wa"}, 64'(a), ew ? 64'(ewa) : 64'd0);
    chk({tag, "_i"},  64'(d), ew ? 64'(ei)  : 64'd0);
    chk({tag, "_ip"}, 64'(p), ew ? 64'(32'h1000 + 32'(ewa)) : 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.stall   = 1'b0;
    bus.src_v   = '0;
    bus.src_tgt = '0;
    bus.src_res = '0;
    bus.src_ip  = '0;
    #2;
    chk("rst_rdy",   64'(bus.src_rdy), 64'd0);
    chk("rst_count", 64'(bus.count),   64'd0);
    chk("rst_empty", 64'(bus.empty),   64'd1);
    chk_port("rst_p0", 0, 1'b0, 6'd0, '0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(bus.src_rdy), 64'd1);

    // single result, no bypass
    set_src(0, 6'd5, 64'h11);
    #1;
    chk("t1_nobypass_wr0", 64'(bus.wr0), 64'd0);
    step();
    clr_src();
    chk("t1_count", 64'(bus.count), 64'd1);
    chk_port("t1_p0", 0, 1'b1, 6'd5, 64'h11);
    chk_port("t1_p1", 1, 1'b0, 6'd0, '0);
    chk_port("t1_p2", 2, 1'b0, 6'd0, '0);
    step();
    chk("t1_empty", 64'(bus.empty), 64'd1);
    chk("t1_count0", 64'(bus.count), 64'd0);

    // four sources, same-register pair kept in order
    set_src(0, 6'd3, 64'hA);
    set_src(1, 6'd3, 64'hB);
    set_src(2, 6'd7, 64'hC);
    set_src(3, 6'd9, 64'hD);
    step();
    clr_src();
    chk("t2_count4", 64'(bus.count), 64'd4);
    chk_port("t2_c1p0", 0, 1'b1, 6'd3, 64'hA);
    chk_port("t2_c1p1", 1, 1'b1, 6'd3, 64'hB);
    chk_port("t2_c1p2", 2, 1'b1, 6'd7, 64'hC);
    step();
    chk("t2_count1", 64'(bus.count), 64'd1);
    chk_port("t2_c2p0", 0, 1'b1, 6'd9, 64'hD);
    chk_port("t2_c2p1", 1, 1'b0, 6'd0, '0);
    step();
    chk("t2_count0", 64'(bus.count), 64'd0);

    // tgt 0 is accepted but discarded
    set_src(0, 6'd0, 64'hDEAD);
    set_src(1, 6'd4, 64'h44);
    step();
    clr_src();
    chk("t3_count", 64'(bus.count), 64'd1);
    chk_port("t3_p0", 0, 1'b1, 6'd4, 64'h44);
    chk_port("t3_p1", 1, 1'b0, 6'd0, '0);
    step();
    chk("t3_count0", 64'(bus.count), 64'd0);

    // fill under stall; tail starts at 6 so contents wrap 7->0
    bus.stall = 1'b1;
    for (int s = 0; s < 4; s++) set_src(s, 6'(10 + s), 64'(8'hA0 + s));
    step();
    chk("t4_count4", 64'(bus.count), 64'd4);
    chk("t4_rdy4",   64'(bus.src_rdy), 64'd1);
    chk("t4_wr0_st", 64'(bus.wr0), 64'd0);
    for (int s = 0; s < 4; s++) set_src(s, 6'(14 + s), 64'(8'hA4 + s));
    step();
    chk("t4_count8", 64'(bus.count), 64'd8);
    chk("t4_rdy8",   64'(bus.src_rdy), 64'd0);
    chk_port("t4_full_p0", 0, 1'b0, 6'd0, '0);
    chk_port("t4_full_p2", 2, 1'b0, 6'd0, '0);
    for (int s = 0; s < 4; s++) set_src(s, 6'(40 + s), 64'hBAD);
    step();
    clr_src();
    chk("t4_norefuse_count", 64'(bus.count), 64'd8);
    bus.stall = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) chk_port($sformatf("t4_d0p%0d", j), j, 1'b1, 6'(10 + j), 64'(8'hA0 + j));
    step();
    chk("t4_count5", 64'(bus.count), 64'd5);
    for (int j = 0; j < 3; j++) chk_port($sformatf("t4_d1p%0d", j), j, 1'b1, 6'(13 + j), 64'(8'hA3 + j));
    step();
    chk("t4_count2", 64'(bus.count), 64'd2);
    chk_port("t4_d2p0", 0, 1'b1, 6'd16, 64'hA6);
    chk_port("t4_d2p1", 1, 1'b1, 6'd17, 64'hA7);
    chk_port("t4_d2p2", 2, 1'b0, 6'd0, '0);
    step();
    chk("t4_count0", 64'(bus.count), 64'd0);

    // steady three per cycle against a scoreboard
    for (int c = 0; c < 6; c++) begin
      clr_src();
      for (int s = 0; s < 3; s++) begin
        set_src(s, 6'(20 + 3 * c + s), 64'(16'h500 + 3 * c + s));
        sb_tgt.push_back(6'(20 + 3 * c + s));
        sb_res.push_back(64'(16'h500 + 3 * c + s));
      end
      step();
      chk($sformatf("t5_count_c%0d", c), 64'(bus.count), 64'd3);
      for (int j = 0; j < 3; j++) begin
        logic [5:0]        et;
        logic [DATA_W-1:0] er;
        et = sb_tgt.pop_front();
        er = sb_res.pop_front();
        chk_port($sformatf("t5_c%0dp%0d", c, j), j, 1'b1, et, er);
      end
    end
    clr_src();
    step();
    chk("t5_count0", 64'(bus.count), 64'd0);
    chk("t5_wr0", 64'(bus.wr0), 64'd0);

    // reset with five queued
    bus.stall = 1'b1;
    for (int s = 0; s < 4; s++) set_src(s, 6'(30 + s), 64'(8'hC0 + s));
    step();
    clr_src();
    set_src(0, 6'd34, 64'hC4);
    step();
    clr_src();
    chk("t6_count5", 64'(bus.count), 64'd5);
    bus.stall = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_count_rst", 64'(bus.count), 64'd0);
    chk("t6_empty_rst", 64'(bus.empty), 64'd1);
    chk("t6_rdy_rst",   64'(bus.src_rdy), 64'd0);
    chk_port("t6_rst_p0", 0, 1'b0, 6'd0, '0);
    chk_port("t6_rst_p2", 2, 1'b0, 6'd0, '0);
    step();
    rst = 1'b0;
    set_src(0, 6'd40, 64'h4040);
    step();
    clr_src();
    chk("t6_count1", 64'(bus.count), 64'd1);
    chk_port("t6_p0", 0, 1'b1, 6'd40, 64'h4040);
    chk_port("t6_p1", 1, 1'b0, 6'd0, '0);
    step();
    chk("t6_empty", 64'(bus.empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
